penc_scan: RTL and testbench

Sequential, parametrised priority encoder that accepts a request vector and emits the index of every set bit, one per output beat, highest priority first. It sits between request-collection logic (interrupt or event masks) and a serial consumer that services one index at a time. It replaces the single-shot combinational encode with a scan that reports every set bit, handles backpressure and flags the all-zero case explicitly.

---
 rtl/penc_scan.sv | 143 ++++++++++++++
 tb/tb_penc_scan.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/penc_scan.sv
// ---------------------------------------------------------------------------
// penc_scan -- sequential priority encoder.
//
// Takes a request vector and emits the index of every set bit, one beat per
// index, highest priority first. An all-zero vector gives a single beat that
// is flagged with out_zero.
//
// Build option:
//   PENC_SCAN_LSB_FIRST_EN  defined -> lowest set bit is reported first.
//                           undefined -> highest set bit first (default).
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_vec is valid
//   in_ready   out  vector can be accepted this cycle
//   in_vec     in   request vector (WIDTH)
//   out_valid  out  out_idx / out_last / out_zero are valid
//   out_ready  in   consumer takes the current beat
//   out_idx    out  index of the current pending bit (IDX_W)
//   out_last   out  final beat of the current vector
//   out_zero   out  accepted vector was all-zero, beat carries no index
//   busy       out  a vector is held and not yet fully emitted
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no vector held, ready to accept
// SCAN  | presenting the selected bit of pend_q, one beat per index
// ---------------------------------------------------------------------------
module penc_scan #(
   parameter int WIDTH = 8,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             out_zero,
   output logic             busy
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             zflag_q, zflag_d;

   logic [IDX_W-1:0] sel_idx;
   logic [WIDTH-1:0] sel_oh;
   logic             multi;

   // Select the priority bit of pend_q. The loop runs from lowest to highest
   // priority so the last match wins.
   always_comb begin
      sel_idx = '0;
      sel_oh  = '0;
`ifdef PENC_SCAN_LSB_FIRST_EN
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            sel_idx   = IDX_W'(i);
            sel_oh    = '0;
            sel_oh[i] = 1'b1;
         end
      end
`else
      for (int i = 0; i < WIDTH; i++) begin
         if (pend_q[i]) begin
            sel_idx   = IDX_W'(i);
            sel_oh    = '0;
            sel_oh[i] = 1'b1;
         end
      end
`endif
   end

   // More than one bit pending: x & (x-1) strips the lowest set bit.
   assign multi = |(pend_q & (pend_q - WIDTH'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pend_q  <= '0;
         zflag_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         zflag_q <= zflag_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      zflag_d = zflag_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = ST_SCAN;
               pend_d  = in_vec;
               zflag_d = ~|in_vec;
            end
         end
         ST_SCAN: begin
            if (out_ready) begin
               if (multi) begin
                  pend_d = pend_q & ~sel_oh;
               end else begin
                  state_d = ST_IDLE;
                  pend_d  = '0;
                  zflag_d = 1'b0;
                  // last beat leaves while the next vector loads: no bubble
                  if (in_valid) begin
                     state_d = ST_SCAN;
                     pend_d  = in_vec;
                     zflag_d = ~|in_vec;
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      busy      = (state_q == ST_SCAN);
      out_valid = busy;
      out_idx   = (busy && !zflag_q) ? sel_idx : '0;
      out_last  = busy && !multi;
      out_zero  = busy && zflag_q;
      in_ready  = !busy || (out_ready && !multi);
   end

endmodule

// File: tb/tb_penc_scan.sv
module tb_penc_scan;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] in_vec;
   logic [2:0] out_idx;
   logic       out_last, out_zero, busy;

   logic        v16, rdy16, ir16, ov16, last16, zero16, busy16;
   logic [15:0] vec16;
   logic [3:0]  idx16;

   int vec_cnt = 0;
   int err_cnt = 0;

   int a_seq[3];
   int b_seq[2];
   int f_seq[3];
   int w_seq[2];

   always #5 clk = ~clk;

   penc_scan #(.WIDTH(8)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
      .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
      .out_last(out_last), .out_zero(out_zero), .busy(busy)
   );

   penc_scan #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v16), .in_ready(ir16), .in_vec(vec16),
      .out_valid(ov16), .out_ready(rdy16), .out_idx(idx16),
      .out_last(last16), .out_zero(zero16), .busy(busy16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   initial begin
`ifdef PENC_SCAN_LSB_FIRST_EN
      a_seq = '{2, 5, 7};
      b_seq = '{0, 7};
      f_seq = '{0, 1, 2};
      w_seq = '{0, 15};
`else
      a_seq = '{7, 5, 2};
      b_seq = '{7, 0};
      f_seq = '{7, 6, 5};
      w_seq = '{15, 0};
`endif
      rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
      v16 = 1'b0; vec16 = '0; rdy16 = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_idx",   out_idx,   0);
      chk("rst_out_last",  out_last,  0);
      chk("rst_out_zero",  out_zero,  0);
      chk("rst_busy",      busy,      0);
      chk("rst_in_ready",  in_ready,  1);
      @(negedge clk);
      rst_n = 1'b1;

      // plain scan of 1010_0100
      @(negedge clk);
      in_valid = 1'b1; in_vec = 8'b1010_0100; out_ready = 1'b1;
      #1 chk("a_in_ready_idle", in_ready, 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         chk("a_valid",    out_valid, 1);
         chk("a_idx",      out_idx,   a_seq[k]);
         chk("a_last",     out_last,  (k == 2) ? 1 : 0);
         chk("a_zero",     out_zero,  0);
         chk("a_busy",     busy,      1);
         chk("a_in_ready", in_ready,  (k == 2) ? 1 : 0);
      end
      @(negedge clk);
      #1;
      chk("a_busy_end",  busy,      0);
      chk("a_valid_end", out_valid, 0);

      // same vector with backpressure; in_vec changes after handshake
      @(negedge clk);
      in_valid = 1'b1; in_vec = 8'b1010_0100; out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         in_valid = 1'b0; in_vec = 8'h00;
         out_ready = (c == 3);
         #1;
         chk("b_hold_idx",  out_idx,  a_seq[0]);
         chk("b_hold_last", out_last, 0);
         chk("b_in_ready",  in_ready, 0);
      end
      for (int k = 1; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk("b_idx",      out_idx,  a_seq[k]);
         chk("b_last",     out_last, (k == 2) ? 1 : 0);
         chk("b_in_ready", in_ready, (k == 2) ? 1 : 0);
      end
      @(negedge clk);
      #1 chk("b_valid_end", out_valid, 0);

      // all-zero vector
      in_valid = 1'b1; in_vec = 8'h00; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("z_valid",    out_valid, 1);
      chk("z_zero",     out_zero,  1);
      chk("z_last",     out_last,  1);
      chk("z_idx",      out_idx,   0);
      chk("z_in_ready", in_ready,  1);
      @(negedge clk);
      #1;
      chk("z_valid_end",    out_valid, 0);
      chk("z_zero_end",     out_zero,  0);
      chk("z_in_ready_end", in_ready,  1);

      // back-to-back 81 then 10
      in_valid = 1'b1; in_vec = 8'h81;
      @(negedge clk);
      in_vec = 8'h10;
      #1;
      chk("bb_idx0",   out_idx,  b_seq[0]);
      chk("bb_last0",  out_last, 0);
      chk("bb_ready0", in_ready, 0);
      @(negedge clk);
      #1;
      chk("bb_idx1",   out_idx,  b_seq[1]);
      chk("bb_last1",  out_last, 1);
      chk("bb_ready1", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("bb_valid2", out_valid, 1);
      chk("bb_idx2",   out_idx,   4);
      chk("bb_last2",  out_last,  1);
      @(negedge clk);
      #1 chk("bb_valid_end", out_valid, 0);

      // reset in the middle of FF
      in_valid = 1'b1; in_vec = 8'hFF;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1 chk("f_idx", out_idx, f_seq[k]);
      end
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b1; in_vec = 8'h02;
      #1;
      chk("f_rst_valid",    out_valid, 0);
      chk("f_rst_in_ready", in_ready,  1);
      chk("f_rst_busy",     busy,      0);
      @(negedge clk);
      #1 chk("f_rst_hold_valid", out_valid, 0);
      rst_n = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("f_new_valid", out_valid, 1);
      chk("f_new_idx",   out_idx,   1);
      chk("f_new_last",  out_last,  1);
      @(negedge clk);
      #1 chk("f_new_end", out_valid, 0);

      // WIDTH=16 instance
      v16 = 1'b1; vec16 = 16'h8001; rdy16 = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         v16 = 1'b0;
         #1;
         chk("w_valid", ov16,   1);
         chk("w_idx",   idx16,  w_seq[k]);
         chk("w_last",  last16, (k == 1) ? 1 : 0);
         chk("w_zero",  zero16, 0);
      end
      @(negedge clk);
      #1;
      chk("w_busy_end", busy16, 0);
      chk("w_ready_end", ir16, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
